// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode of the fetched word feeding
// a main output register backed by a one-entry skid register, with flush.
module decode_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [6:0]          opcode,
   output logic [2:0]          funct3,
   output logic [6:0]          funct7,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic [XLEN-1:0]     imm,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                rf_we,
   output logic                mem_re,
   output logic                mem_we,
   output logic                branch,
   output logic                jump,
   output logic                alu_src_imm,
   output logic                illegal
);

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SLL    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_SLT    = 4'd8,
      ALU_SLTU   = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   typedef struct packed {
      logic [XLEN-1:0]     pc;
      logic [6:0]          opcode;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN-1:0]     imm;
      logic [ALU_OP_W-1:0] alu_op;
      logic                rf_we;
      logic                mem_re;
      logic                mem_we;
      logic                branch;
      logic                jump;
      logic                alu_src_imm;
      logic                illegal;
   } bundle_t;

   function automatic alu_op_e base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   bundle_t     dec;
   alu_op_e     op;
   logic [31:0] imm32;
   logic        ill;
   logic        we, re, wr, br, jmp, src_imm;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign f3 = in_instr[14:12];
   assign f7 = in_instr[31:25];

   always_comb begin
      op      = ALU_ADD;
      imm32   = '0;
      ill     = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      wr      = 1'b0;
      br      = 1'b0;
      jmp     = 1'b0;
      src_imm = 1'b0;
      case (in_instr[6:0])
         OPC_OP: begin
            we = 1'b1;
            if (f7 == 7'b0000000) begin
               op = base_op(f3);
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               op = ALU_SUB;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
               op = ALU_SRA;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            we      = 1'b1;
            src_imm = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            op      = base_op(f3);
            // Only the shift-immediates constrain the upper bits of the immediate field
            if (f3 == 3'b001 && f7 != 7'b0000000) begin
               ill = 1'b1;
            end else if (f3 == 3'b101) begin
               if (f7 == 7'b0100000)      op  = ALU_SRA;
               else if (f7 != 7'b0000000) ill = 1'b1;
            end
         end
         OPC_LOAD: begin
            we      = 1'b1;
            re      = 1'b1;
            src_imm = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            ill     = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
         end
         OPC_STORE: begin
            wr      = 1'b1;
            src_imm = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            ill     = !(f3 inside {3'b000, 3'b001, 3'b010});
         end
         OPC_BRANCH: begin
            br    = 1'b1;
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
            case (f3)
               3'b000, 3'b001: op  = ALU_SUB;
               3'b100, 3'b101: op  = ALU_SLT;
               3'b110, 3'b111: op  = ALU_SLTU;
               default:        ill = 1'b1;
            endcase
         end
         OPC_JAL: begin
            jmp   = 1'b1;
            we    = 1'b1;
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
         end
         OPC_JALR: begin
            jmp     = 1'b1;
            we      = 1'b1;
            src_imm = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            ill     = (f3 != 3'b000);
         end
         OPC_LUI: begin
            op      = ALU_PASS_B;
            we      = 1'b1;
            src_imm = 1'b1;
            imm32   = {in_instr[31:12], 12'h000};
         end
         OPC_AUIPC: begin
            we      = 1'b1;
            src_imm = 1'b1;
            imm32   = {in_instr[31:12], 12'h000};
         end
         default: ill = 1'b1;
      endcase

      // Illegal words still flow downstream so execute can trap, but must be inert
      if (ill) begin
         op      = ALU_ADD;
         we      = 1'b0;
         re      = 1'b0;
         wr      = 1'b0;
         br      = 1'b0;
         jmp     = 1'b0;
         src_imm = 1'b0;
      end
      if (in_instr[11:7] == 5'd0) we = 1'b0;

      dec             = '0;
      dec.pc          = in_pc;
      dec.opcode      = in_instr[6:0];
      dec.funct3      = f3;
      dec.funct7      = f7;
      dec.rs1         = in_instr[19:15];
      dec.rs2         = in_instr[24:20];
      dec.rd          = in_instr[11:7];
      dec.imm         = XLEN'($signed(imm32));
      dec.alu_op      = ALU_OP_W'(op);
      dec.rf_we       = we;
      dec.mem_re      = re;
      dec.mem_we      = wr;
      dec.branch      = br;
      dec.jump        = jmp;
      dec.alu_src_imm = src_imm;
      dec.illegal     = ill;
   end

   bundle_t main_q, main_d, skid_q, skid_d;
   logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic    accept;

   assign in_ready = !skid_valid_q;
   assign accept   = in_valid && !skid_valid_q;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_d       = '0;
         skid_d       = '0;
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // A full skid implies a full main and in_ready=0, so nothing new arrives here
         if (out_ready) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q || out_ready) begin
            main_d       = dec;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else if (main_valid_q && out_ready) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign out_pc      = main_q.pc;
   assign opcode      = main_q.opcode;
   assign funct3      = main_q.funct3;
   assign funct7      = main_q.funct7;
   assign rs1         = main_q.rs1;
   assign rs2         = main_q.rs2;
   assign rd          = main_q.rd;
   assign imm         = main_q.imm;
   assign alu_op      = main_q.alu_op;
   assign rf_we       = main_q.rf_we;
   assign mem_re      = main_q.mem_re;
   assign mem_we      = main_q.mem_we;
   assign branch      = main_q.branch;
   assign jump        = main_q.jump;
   assign alu_src_imm = main_q.alu_src_imm;
   assign illegal     = main_q.illegal;

endmodule
